// File: rtl/adder_vector_checker.sv
// Vector engine that drives an external adder and checks its sum/carry.
// Vectors are loaded into a small memory and replayed on start.
module adder_vector_checker #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [3*WIDTH+1:0]   load_data,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_vectors,
  input  logic                 stop_on_err,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_ci,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_co,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    vect_idx,
  output logic                 first_err_valid,
  output logic [ADDR_W-1:0]    first_err_idx
);

  localparam int VW = 3*WIDTH+2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  logic [VW-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic              soe_q, soe_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              ci_q, ci_d;
  logic [WIDTH-1:0]  sexp_q, sexp_d;
  logic              coexp_q, coexp_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [ADDR_W-1:0] fei_q, fei_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              idle_like;
  logic              go;
  logic              mismatch;
  logic              last;
  logic [ADDR_W:0]   n_clamp;
  logic [VW-1:0]     rd;

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (load_en && idle_like &&
        ({1'b0, load_addr} < (ADDR_W+1)'(DEPTH)))
      mem[load_addr] <= load_data;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    n_d      = n_q;
    soe_d    = soe_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    sexp_d   = sexp_q;
    coexp_d  = coexp_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fei_d    = fei_q;
    go       = start && idle_like;
    rd       = mem[idx_q];
    n_clamp  = (num_vectors > (ADDR_W+1)'(DEPTH)) ?
               (ADDR_W+1)'(DEPTH) : num_vectors;
    mismatch = (dut_s !== sexp_q) ||
               (dut_co !== coexp_q);
    last     = ({1'b0, idx_q} ==
                n_q - (ADDR_W+1)'(1));
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          err_d = '0;
          fev_d = 1'b0;
          fei_d = '0;
          if (n_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            n_d     = n_clamp;
            soe_d   = stop_on_err;
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        a_d     = rd[VW-1 -: WIDTH];
        b_d     = rd[VW-1-WIDTH -: WIDTH];
        ci_d    = rd[WIDTH+1];
        sexp_d  = rd[WIDTH:1];
        coexp_d = rd[0];
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE-1))
          state_d = S_CHECK;
        else
          cnt_d = cnt_q + CW'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1)
            err_d = err_q + ERR_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end
        end
        if (last || (soe_q && mismatch)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_APPLY) ||
             (state_d == S_SETTLE) ||
             (state_d == S_CHECK);
    // done/pass trail DONE entry by a cycle
    done_d = (state_q == S_DONE) && !go;
    pass_d = done_d && (err_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      soe_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      sexp_q  <= '0;
      coexp_q <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      soe_q   <= soe_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      sexp_q  <= sexp_d;
      coexp_q <= coexp_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a           = a_q;
  assign dut_b           = b_q;
  assign dut_ci          = ci_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign vect_idx        = idx_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_adder_vector_checker.sv
// Directed bench for adder_vector_checker with behavioural adders.
// A second instance with ERR_W=2 shares stimulus to check saturation.
module tb_adder_vector_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [13:0] load_data = '0;
  logic        start = 1'b0;
  logic [4:0]  num_vectors = '0;
  logic        stop_on_err = 1'b0;

  logic [3:0] dut_a, dut_b, dut_s;
  logic       dut_ci, dut_co;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] vect_idx, first_err_idx;
  logic       first_err_valid;

  logic [3:0] s_a, s_b, s_s;
  logic       s_ci, s_co;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_err;
  logic [3:0] s_idx, s_fei;
  logic       s_fev;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {dut_co, dut_s} = dut_a + dut_b + {3'b0, dut_ci};
  assign {s_co, s_s}     = s_a + s_b + {3'b0, s_ci};

  adder_vector_checker #(
    .WIDTH(4), .DEPTH(16), .ADDR_W(4),
    .ERR_W(8), .SETTLE(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start),
    .num_vectors(num_vectors),
    .stop_on_err(stop_on_err),
    .dut_a(dut_a), .dut_b(dut_b),
    .dut_ci(dut_ci), .dut_s(dut_s),
    .dut_co(dut_co), .busy(busy),
    .done(done), .pass(pass),
    .err_count(err_count),
    .vect_idx(vect_idx),
    .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx)
  );

  adder_vector_checker #(
    .WIDTH(4), .DEPTH(16), .ADDR_W(4),
    .ERR_W(2), .SETTLE(1)
  ) u_sat (
    .clk(clk), .reset_n(reset_n),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start),
    .num_vectors(num_vectors),
    .stop_on_err(stop_on_err),
    .dut_a(s_a), .dut_b(s_b),
    .dut_ci(s_ci), .dut_s(s_s),
    .dut_co(s_co), .busy(s_busy),
    .done(s_done), .pass(s_pass),
    .err_count(s_err),
    .vect_idx(s_idx),
    .first_err_valid(s_fev),
    .first_err_idx(s_fei)
  );

  function automatic logic [13:0] bad_vec(
    input logic [3:0] a, input logic [3:0] b
  );
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b};
    return {a, b, 1'b0, r[3:0] ^ 4'b0001, r[4]};
  endfunction

  task automatic do_load(
    input int addr, input logic [13:0] d
  );
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 4'(addr);
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_good3();
    do_load(0, 14'b0011_0101_0_1000_0);
    do_load(1, 14'b1111_0001_0_0000_1);
    do_load(2, 14'b0111_0111_1_1111_0);
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got %0d cycles", cyc);
    end
  endtask

  task automatic run(
    input int n, input logic soe, output int cyc
  );
    @(negedge clk);
    num_vectors = 5'(n);
    stop_on_err = soe;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    wait_done(cyc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, err_count, vect_idx,
         first_err_valid, first_err_idx,
         dut_a, dut_b, dut_ci} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b err=%0d idx=%0d",
               busy, done, err_count, vect_idx);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_pass3();
    int cyc;
    load_good3();
    run(3, 1'b0, cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL pass3_latency got %0d want 10", cyc);
    end
    checks++;
    if ({pass, err_count, vect_idx, busy} !==
        {1'b1, 8'd0, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL pass3_status pass=%b err=%0d idx=%0d busy=%b want 1 0 2 0",
               pass, err_count, vect_idx, busy);
    end
  endtask

  task automatic test_co_only();
    int cyc;
    do_load(0, 14'b1111_0001_0_0000_0);
    run(1, 1'b0, cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL co_latency got %0d want 4", cyc);
    end
    checks++;
    if ({pass, err_count, first_err_valid, first_err_idx} !==
        {1'b0, 8'd1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL co_only pass=%b err=%0d fev=%b fei=%0d want 0 1 1 0",
               pass, err_count, first_err_valid, first_err_idx);
    end
  endtask

  task automatic test_stop_on_err();
    int cyc;
    do_load(0, 14'b0001_0010_0_0011_0);
    do_load(1, 14'b0010_0011_0_0110_0);
    do_load(2, 14'b0100_0100_1_1001_0);
    do_load(3, 14'b1000_1001_0_0001_1);
    run(4, 1'b1, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL stop_latency got %0d want 7", cyc);
    end
    checks++;
    if ({vect_idx, err_count, first_err_idx} !==
        {4'd1, 8'd1, 4'd1}) begin
      errors++;
      $display("FAIL stop_status idx=%0d err=%0d fei=%0d want 1 1 1",
               vect_idx, err_count, first_err_idx);
    end
    run(4, 1'b0, cyc);
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("FAIL nostop_latency got %0d want 13", cyc);
    end
    checks++;
    if ({vect_idx, err_count, first_err_idx, pass} !==
        {4'd3, 8'd1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL nostop_status idx=%0d err=%0d fei=%0d pass=%b want 3 1 1 0",
               vect_idx, err_count, first_err_idx, pass);
    end
  endtask

  task automatic test_zero();
    int cyc;
    run(0, 1'b0, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL zero_latency got %0d want 1", cyc);
    end
    checks++;
    if ({pass, err_count, busy} !== {1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL zero_status pass=%b err=%0d busy=%b want 1 0 0",
               pass, err_count, busy);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    for (int i = 0; i < 5; i++)
      do_load(i, bad_vec(4'(i), 4'(i + 3)));
    run(5, 1'b0, cyc);
    checks++;
    if (err_count !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide_err got %0d want 5", err_count);
    end
    checks++;
    if ({s_err, s_fev, s_fei, s_pass, s_done} !==
        {2'd3, 1'b1, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_narrow err=%0d fev=%b fei=%0d pass=%b done=%b want 3 1 0 0 1",
               s_err, s_fev, s_fei, s_pass, s_done);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    for (int i = 0; i < 16; i++)
      do_load(i, bad_vec(4'(i), 4'(15 - i)));
    run(20, 1'b0, cyc);
    checks++;
    if (cyc !== 49) begin
      errors++;
      $display("FAIL clamp_latency got %0d want 49", cyc);
    end
    checks++;
    if ({err_count, vect_idx} !== {8'd16, 4'd15}) begin
      errors++;
      $display("FAIL clamp_status err=%0d idx=%0d want 16 15",
               err_count, vect_idx);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_good3();
    @(negedge clk);
    num_vectors = 5'd3;
    stop_on_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if ({busy, vect_idx} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL mid_pre busy=%b idx=%0d want 1 2",
               busy, vect_idx);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, err_count, vect_idx,
         first_err_valid, first_err_idx,
         dut_a, dut_b, dut_ci} !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b idx=%0d a=%h b=%h",
               busy, done, vect_idx, dut_a, dut_b);
    end
    reset_n = 1'b1;
    run(3, 1'b0, cyc);
    checks++;
    if ({cyc == 10, pass, err_count} !==
        {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL mid_rerun cyc=%0d pass=%b err=%0d want 10 1 0",
               cyc, pass, err_count);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    num_vectors = 5'd3;
    stop_on_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = 14'b0011_0101_0_0000_1;
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    cyc = 1;
    wait_done(cyc);
    checks++;
    if ({cyc == 10, pass} !== 2'b11) begin
      errors++;
      $display("FAIL busy_ignore cyc=%0d pass=%b want 10 1",
               cyc, pass);
    end
    run(3, 1'b0, cyc);
    checks++;
    if ({cyc == 10, pass, err_count} !==
        {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL b2b_rerun cyc=%0d pass=%b err=%0d want 10 1 0",
               cyc, pass, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_pass3();
    test_co_only();
    test_stop_on_err();
    test_zero();
    test_saturate();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
